csr_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for Zicsr instructions in the RV32I trap core. Sits between the decoder and the single-port, synchronous-read CSR file.
- Selects the immediate-generator type so the zimm operand (rs1 field, zero-extended by type 3'b111) reaches the datapath.
- Checks legality, then runs one read-modify-write of the CSR. Writes the old CSR value to rd, or raises an illegal-instruction trap request.

---
 rtl/csr_seq_ctrl_if.sv | 45 ++++
 rtl/csr_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_csr_seq_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_seq_ctrl_if.sv
// Decoder, CSR-file and register-file signals of the Zicsr sequencer, bundled.
// slave = sequencer side, master = decoder/CSR-file/regfile side.
interface csr_seq_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int PRIV_W = 2
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        funct3;
  logic [11:0]       csr_addr_in;
  logic [4:0]        rs1_idx;
  logic [4:0]        rd_idx;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   imm_data;
  logic [PRIV_W-1:0] priv;
  logic [2:0]        imm_typ;
  logic              flush;

  logic [11:0]       csr_addr;
  logic              csr_re;
  logic [XLEN-1:0]   csr_rdata;
  logic              csr_exists;
  logic              csr_we;
  logic [XLEN-1:0]   csr_wdata;

  logic              rd_we;
  logic [4:0]        rd_waddr;
  logic [XLEN-1:0]   rd_wdata;
  logic              done;
  logic              illegal;

  modport slave (
    input  req_valid, funct3, csr_addr_in, rs1_idx, rd_idx, rs1_data, imm_data,
           priv, flush, csr_rdata, csr_exists,
    output req_ready, imm_typ, csr_addr, csr_re, csr_we, csr_wdata,
           rd_we, rd_waddr, rd_wdata, done, illegal
  );

  modport master (
    output req_valid, funct3, csr_addr_in, rs1_idx, rd_idx, rs1_data, imm_data,
           priv, flush, csr_rdata, csr_exists,
    input  req_ready, imm_typ, csr_addr, csr_re, csr_we, csr_wdata,
           rd_we, rd_waddr, rd_wdata, done, illegal
  );
endinterface

// File: rtl/csr_seq_ctrl.sv
// Zicsr read-modify-write sequencer: IDLE -> CHECK -> READ -> WRITE (or CHECK -> FAULT).
// Optional macro CSR_RO_CHECK_EN: writes to read-only CSRs (addr[11:10]==2'b11) trap as illegal.
module csr_seq_ctrl #(
  parameter int PRIV_W = 2,
  parameter int XLEN   = 32
) (
  input logic         clk,
  input logic         rst_n,
  csr_seq_ctrl_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  logic [2:0]        state_q,    state_d;
  logic [2:0]        funct3_q,   funct3_d;
  logic [11:0]       csr_addr_q, csr_addr_d;
  logic [4:0]        rs1_idx_q,  rs1_idx_d;
  logic [4:0]        rd_idx_q,   rd_idx_d;
  logic [PRIV_W-1:0] priv_q,     priv_d;
  logic [XLEN-1:0]   op_q,       op_d;

  logic [1:0]      op_kind;
  logic            wr_int;
  logic            rd_int;
  logic            ro_addr;
  logic            ro_fault;
  logic            write_allowed;
  logic            priv_low;
  logic            is_illegal;
  logic            live;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;

  // Operand intent is a pure function of the latched instruction fields.
  always_comb begin
    op_kind  = funct3_q[1:0];
    wr_int   = (op_kind == OP_RW) || (rs1_idx_q != 5'd0);
    rd_int   = !((op_kind == OP_RW) && (rd_idx_q == 5'd0));
    ro_addr  = (csr_addr_q[11:10] == 2'b11);
    priv_low = (priv_q < PRIV_W'(csr_addr_q[9:8]));
  end

`ifdef CSR_RO_CHECK_EN
  assign ro_fault      = wr_int && ro_addr;
  assign write_allowed = wr_int;
`else
  // Without the check the op retires normally but never touches a read-only CSR.
  assign ro_fault      = 1'b0;
  assign write_allowed = wr_int && !ro_addr;
`endif

  assign is_illegal = (op_kind == 2'b00) || !bus.csr_exists || priv_low || ro_fault;

  always_comb begin
    old_val = rd_int ? bus.csr_rdata : '0;
    case (op_kind)
      OP_RW:   new_val = op_q;
      OP_RS:   new_val = old_val | op_q;
      OP_RC:   new_val = old_val & ~op_q;
      default: new_val = op_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    funct3_d   = funct3_q;
    csr_addr_d = csr_addr_q;
    rs1_idx_d  = rs1_idx_q;
    rd_idx_d   = rd_idx_q;
    priv_d     = priv_q;
    op_d       = op_q;
    case (state_q)
      S_IDLE: begin
        // A flush in the same cycle as a request swallows the request.
        if (bus.req_valid && !bus.flush) begin
          funct3_d   = bus.funct3;
          csr_addr_d = bus.csr_addr_in;
          rs1_idx_d  = bus.rs1_idx;
          rd_idx_d   = bus.rd_idx;
          priv_d     = bus.priv;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        op_d    = funct3_q[2] ? bus.imm_data : bus.rs1_data;
        state_d = is_illegal ? S_FAULT : S_READ;
      end
      S_READ:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if ((state_q != S_IDLE) && bus.flush) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      funct3_q   <= '0;
      csr_addr_q <= '0;
      rs1_idx_q  <= '0;
      rd_idx_q   <= '0;
      priv_q     <= '0;
      op_q       <= '0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      csr_addr_q <= csr_addr_d;
      rs1_idx_q  <= rs1_idx_d;
      rd_idx_q   <= rd_idx_d;
      priv_q     <= priv_d;
      op_q       <= op_d;
    end
  end

  // Strobes come straight from the registered state, killed by a same-cycle flush.
  assign live = !bus.flush;

  always_comb begin
    bus.req_ready = (state_q == S_IDLE);
    bus.imm_typ   = ((state_q == S_CHECK) && funct3_q[2]) ? 3'b111 : 3'b000;
    bus.csr_addr  = (state_q != S_IDLE) ? csr_addr_q : 12'd0;
    bus.csr_re    = (state_q == S_READ) && rd_int && live;
    bus.csr_we    = (state_q == S_WRITE) && write_allowed && live;
    bus.csr_wdata = (state_q == S_WRITE) ? new_val : '0;
    bus.rd_we     = (state_q == S_WRITE) && rd_int && (rd_idx_q != 5'd0) && live;
    bus.rd_waddr  = (state_q == S_WRITE) ? rd_idx_q : 5'd0;
    bus.rd_wdata  = (state_q == S_WRITE) ? old_val : '0;
    bus.done      = (state_q == S_WRITE) && live;
    bus.illegal   = (state_q == S_FAULT) && live;
  end
endmodule

// File: tb/tb_csr_seq_ctrl.sv
// Scoreboard bench for csr_seq_ctrl: driver pushes model predictions, a negedge monitor pops them.
// Honours CSR_RO_CHECK_EN the same way the design does.
module tb_csr_seq_ctrl;
  localparam int XLEN   = 32;
  localparam int PRIV_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  csr_seq_ctrl_if #(.XLEN(XLEN), .PRIV_W(PRIV_W)) bus();
  csr_seq_ctrl #(.PRIV_W(PRIV_W), .XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    bit          is_illegal;
    bit          csr_re;
    bit          csr_we;
    logic [31:0] wdata;
    bit          rd_we;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic [11:0] addr;
    int          accept_cyc;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit [31:0]   csr_mem [4096];
  bit [31:0]   ref_mem [4096];
  logic [4:0]  zimm_hold;
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [31:0] pre_val;

  function automatic bit present(input logic [11:0] a);
    return a[7:0] != 8'hFF;
  endfunction

  // Environment: imm_gen, CSR existence decode and a synchronous-read CSR file.
  assign bus.imm_data   = (bus.imm_typ == 3'b111) ? {27'b0, zimm_hold} : 32'hBAD0_BAD0;
  assign bus.csr_exists = present(bus.csr_addr);

  always @(posedge clk) begin
    if (pre_we) csr_mem[pre_addr] <= pre_val;
    else if (bus.csr_we) csr_mem[bus.csr_addr] <= bus.csr_wdata;
    if (bus.csr_re) bus.csr_rdata <= csr_mem[bus.csr_addr];
    else bus.csr_rdata <= $urandom;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: Zicsr semantics straight from the instruction rules.
  function automatic exp_t model(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1,
                                 input logic [4:0] rd, input logic [31:0] rs1v, input logic [1:0] pv);
    exp_t e;
    logic [31:0] op;
    logic [31:0] old;
    bit writes;
    bit reads;
    bit ro;
    bit legal;
    writes = (f3[1:0] == 2'b01) || (rs1 != 5'd0);
    reads  = !((f3[1:0] == 2'b01) && (rd == 5'd0));
    ro     = (a[11:10] == 2'b11);
    legal  = (f3[1:0] != 2'b00) && present(a) && (pv >= a[9:8]);
`ifdef CSR_RO_CHECK_EN
    if (writes && ro) legal = 1'b0;
`endif
    e = '{default: '0};
    e.addr = a;
    e.is_illegal = !legal;
    if (legal) begin
      op  = f3[2] ? {27'b0, rs1} : rs1v;
      old = reads ? ref_mem[a] : 32'd0;
      e.csr_re = reads;
      e.csr_we = writes && !ro;
      case (f3[1:0])
        2'b01:   e.wdata = op;
        2'b10:   e.wdata = old | op;
        default: e.wdata = old & ~op;
      endcase
      e.rd_we    = reads && (rd != 5'd0);
      e.rd_waddr = rd;
      e.rd_wdata = old;
    end
    return e;
  endfunction

  // Monitor: pops one expectation per done/illegal pulse.
  bit re_seen = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.csr_re && sb.size() > 0) re_seen = 1'b1;
      if (bus.done || bus.illegal) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: got done=%0b illegal=%0b expected no pulse", bus.done, bus.illegal);
        end else begin
          e = sb.pop_front();
          $display("txn addr=%h illegal=%0b csr_we=%0b wdata=%h rd_we=%0b rd=%0d rd_wdata=%h",
                   e.addr, bus.illegal, bus.csr_we, bus.csr_wdata, bus.rd_we, bus.rd_waddr, bus.rd_wdata);
          check("kind_illegal", 32'(bus.illegal), 32'(e.is_illegal));
          check("kind_done", 32'(bus.done), 32'(!e.is_illegal));
          check("latency", 32'(cyc - e.accept_cyc + 1), e.is_illegal ? 32'd2 : 32'd3);
          check("csr_re_seen", 32'(re_seen), 32'(e.csr_re));
          check("csr_we", 32'(bus.csr_we), 32'(e.csr_we));
          if (e.csr_we) begin
            check("csr_wdata", bus.csr_wdata, e.wdata);
            check("csr_addr", 32'(bus.csr_addr), 32'(e.addr));
          end
          check("rd_we", 32'(bus.rd_we), 32'(e.rd_we));
          if (e.rd_we) begin
            check("rd_waddr", 32'(bus.rd_waddr), 32'(e.rd_waddr));
            check("rd_wdata", bus.rd_wdata, e.rd_wdata);
          end
        end
        re_seen = 1'b0;
      end else if (bus.csr_we || bus.rd_we) begin
        checks++;
        errors++;
        $display("FAIL stray_write: got csr_we=%0b rd_we=%0b expected 0 outside retire", bus.csr_we, bus.rd_we);
      end
    end
  end

  task automatic set_csr(input logic [11:0] a, input logic [31:0] v);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = a; pre_val = v;
    @(posedge clk); #1;
    pre_we = 1'b0;
    ref_mem[a] = v;
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1,
                        input logic [4:0] rd, input logic [31:0] rs1v, input logic [1:0] pv,
                        input bit flush_req);
    exp_t e;
    bit do_flush;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.funct3 = f3; bus.csr_addr_in = a;
    bus.rs1_idx = rs1; bus.rd_idx = rd; bus.rs1_data = rs1v; bus.priv = pv;
    zimm_hold = rs1;
    @(posedge clk); #1;
    e = model(f3, a, rs1, rd, rs1v, pv);
    e.accept_cyc = cyc;
    do_flush = flush_req && !e.is_illegal;
    if (!do_flush) begin
      sb.push_back(e);
      if (e.csr_we) ref_mem[a] = e.wdata;
    end
    // Decoder fields are only sampled at accept; disturb them to prove it.
    bus.req_valid = 1'b0; bus.funct3 = 3'($urandom); bus.csr_addr_in = 12'($urandom);
    bus.rd_idx = 5'($urandom); bus.priv = 2'($urandom); bus.rs1_idx = 5'($urandom);
    @(negedge clk);
    check("imm_typ_check", 32'(bus.imm_typ), f3[2] ? 32'd7 : 32'd0);
    @(posedge clk); #1;
    bus.rs1_data = $urandom; zimm_hold = 5'($urandom);
    if (do_flush) begin
      @(posedge clk); #1;
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      @(negedge clk);
      check("ready_after_flush", 32'(bus.req_ready), 32'd1);
    end else begin
      @(posedge clk);
    end
  endtask

  logic [11:0] addr_tab [10] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                 12'h3FF, 12'h100, 12'hF11, 12'hC00, 12'h7C0};

  initial begin
    bus.req_valid = 1'b0; bus.flush = 1'b0; bus.funct3 = '0; bus.csr_addr_in = '0;
    bus.rs1_idx = '0; bus.rd_idx = '0; bus.rs1_data = '0; bus.priv = '0;
    zimm_hold = '0; pre_we = 1'b0; pre_addr = '0; pre_val = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_imm_typ", 32'(bus.imm_typ), 32'd0);
    check("rst_strobes", {27'b0, bus.csr_re, bus.csr_we, bus.rd_we, bus.done, bus.illegal}, 32'd0);
    check("rst_csr_addr", 32'(bus.csr_addr), 32'd0);
    check("rst_csr_wdata", bus.csr_wdata, 32'd0);
    check("rst_rd_waddr", 32'(bus.rd_waddr), 32'd0);
    check("rst_rd_wdata", bus.rd_wdata, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Directed cases
    set_csr(12'h340, 32'h0000_1234);
    run_op(3'b001, 12'h340, 5'd3, 5'd5, 32'hDEAD_BEEF, 2'd3, 1'b0);
    set_csr(12'h341, 32'h0000_0101);
    run_op(3'b110, 12'h341, 5'd10, 5'd2, 32'h5555_0000, 2'd3, 1'b0);
    set_csr(12'h342, 32'h0000_00FF);
    run_op(3'b011, 12'h342, 5'd0, 5'd7, 32'hFFFF_FFFF, 2'd3, 1'b0);
    run_op(3'b001, 12'h305, 5'd4, 5'd0, 32'h0000_0055, 2'd3, 1'b0);
    run_op(3'b001, 12'h300, 5'd1, 5'd1, 32'h0000_0001, 2'd0, 1'b0);
    run_op(3'b010, 12'h3FF, 5'd1, 5'd1, 32'h0000_0001, 2'd3, 1'b0);
    run_op(3'b001, 12'hF11, 5'd2, 5'd3, 32'h1111_1111, 2'd3, 1'b0);
    repeat (3) @(posedge clk);
    check("mem_340", csr_mem[12'h340], 32'hDEAD_BEEF);
    check("mem_341", csr_mem[12'h341], 32'h0000_010B);
    check("mem_342", csr_mem[12'h342], 32'h0000_00FF);
    check("mem_f11", csr_mem[12'hF11], 32'h0000_0000);

    // Flush in the WRITE cycle must leave the CSR untouched
    run_op(3'b001, 12'h340, 5'd9, 5'd9, 32'hCAFE_F00D, 2'd3, 1'b1);
    repeat (3) @(posedge clk);
    check("mem_340_after_flush", csr_mem[12'h340], 32'hDEAD_BEEF);

    // Flush together with a request in IDLE: not accepted
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'b001; bus.csr_addr_in = 12'h340;
    bus.rs1_idx = 5'd1; bus.rd_idx = 5'd1; bus.priv = 2'd3;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check("ready_flush_idle", 32'(bus.req_ready), 32'd1);

    // Asynchronous reset while in READ
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.funct3 = 3'b001; bus.csr_addr_in = 12'h340;
    bus.rs1_idx = 5'd1; bus.rd_idx = 5'd1; bus.rs1_data = 32'h7777_7777; bus.priv = 2'd3;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("read_csr_re", 32'(bus.csr_re), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_strobes", {27'b0, bus.csr_re, bus.csr_we, bus.rd_we, bus.done, bus.illegal}, 32'd0);
    check("midrst_csr_addr", 32'(bus.csr_addr), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    check("mem_340_after_reset", csr_mem[12'h340], 32'hDEAD_BEEF);

    // Randomized traffic
    for (int i = 0; i < 10; i++) set_csr(addr_tab[i], $urandom);
    for (int i = 0; i < 150; i++) begin
      logic [4:0] rs1_r;
      logic [4:0] rd_r;
      rs1_r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rd_r  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      run_op(3'($urandom_range(0, 7)), addr_tab[$urandom_range(0, 9)], rs1_r, rd_r,
             $urandom, 2'($urandom), $urandom_range(0, 9) == 0);
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending retirements expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
